presc_multi: RTL and testbench

Parametrised multi-channel prescaler for the peripheral subsystem: each of `CH` independent channels divides `clk` by a run-time 32-bit ratio and produces both a single-cycle `tick` clock-enable and a square-wave `clk_pre`. It adds several features:
- glitch-free ratio updates, latched only at period boundaries;
- a one-shot mode;
- a global phase-alignment `sync` input.

Timers, the UART baud generator and PWM units consume `tick` as a clock-enable; `clk_pre` exists for observation and slow external strobes.

---
 rtl/presc_multi.sv | 161 ++++++++++++++++
 tb/tb_presc_multi.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/presc_multi.sv
// presc_multi: multi-channel clock prescaler.
// Each channel divides clk by a run-time ratio and produces a registered
// single-cycle tick, a registered square wave clk_pre and a busy flag.
// Ratio changes are taken only at period boundaries. A one-shot mode is
// available, and a global sync input realigns all running channels.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   en         per-channel enable (0 forces the channel idle)
//   oneshot    per-channel mode: 0 periodic, 1 one-shot
//   start      per-channel one-shot trigger (level, ignored when busy)
//   sync       global restart of every running channel
//   prescaler  channel i ratio at [i*WIDTH +: WIDTH]; 0 behaves as 1
//   tick       registered single-cycle pulse per period
//   clk_pre    registered square wave, floor(N/2) high / ceil(N/2) low
//   busy       registered, high while the channel is counting
module presc_multi #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       oneshot,
  input  logic [CH-1:0]       start,
  input  logic                sync,
  input  logic [CH*WIDTH-1:0] prescaler,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       clk_pre,
  output logic [CH-1:0]       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] act_d;
    logic             tick_q;
    logic             tick_d;
    logic             clk_pre_q;
    logic             clk_pre_d;
    logic             busy_q;
    logic             busy_d;

    logic [WIDTH-1:0] ratio;
    logic [WIDTH-1:0] ne_cur;
    logic [WIDTH-1:0] ne_new;
    logic             wrap;
    logic             new_has_high;

    // Ratio 0 is treated as 1 for both the running and the incoming ratio.
    always_comb begin
      ratio        = prescaler[i*WIDTH +: WIDTH];
      ne_cur       = (act_q == '0) ? WIDTH'(1) : act_q;
      ne_new       = (ratio == '0) ? WIDTH'(1) : ratio;
      wrap         = (cnt_q == (ne_cur - WIDTH'(1)));
      // clk_pre at count 0 of a fresh period is high only when Ne >= 2.
      new_has_high = ((ne_new >> 1) != '0);
    end

    // State register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Next-state logic: en=0 beats sync, sync beats a one-shot wrap.
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE: begin
          if (en[i] && (!oneshot[i] || start[i])) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!en[i]) begin
            state_d = IDLE;
          end else if (sync) begin
            state_d = RUN;
          end else if (wrap && oneshot[i]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Counter, ratio latch and output values for the next cycle.
    always_comb begin
      cnt_d     = cnt_q;
      act_d     = act_q;
      tick_d    = 1'b0;
      clk_pre_d = 1'b0;
      busy_d    = (state_d == RUN);
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (state_d == RUN) begin
            act_d = ratio;
          end
        end
        RUN: begin
          if (!en[i]) begin
            cnt_d = '0;
          end else if (sync) begin
            cnt_d     = '0;
            act_d     = ratio;
            clk_pre_d = new_has_high;
          end else if (wrap) begin
            // Period boundary: pick up the new ratio, restart the count.
            cnt_d     = '0;
            act_d     = ratio;
            tick_d    = 1'b1;
            clk_pre_d = (state_d == RUN) && new_has_high;
          end else begin
            // cnt_q < Ne-1 here, so the increment cannot overflow.
            cnt_d     = cnt_q + WIDTH'(1);
            clk_pre_d = ((cnt_q + WIDTH'(1)) < (ne_cur >> 1));
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q     <= '0;
        act_q     <= '0;
        tick_q    <= 1'b0;
        clk_pre_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        act_q     <= act_d;
        tick_q    <= tick_d;
        clk_pre_q <= clk_pre_d;
        busy_q    <= busy_d;
      end
    end

    assign tick[i]    = tick_q;
    assign clk_pre[i] = clk_pre_q;
    assign busy[i]    = busy_q;
  end

endmodule

// File: tb/tb_presc_multi.sv
// Testbench for presc_multi: a 2-channel 32-bit instance and a 1-channel
// 8-bit instance, checked every cycle against a period-level model plus
// directed expectations for the documented scenarios.
module tb_presc_multi;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  en_a, os_a, start_a;
  logic        sync_a;
  logic [63:0] presc_a;
  logic [1:0]  tick_a, clk_pre_a, busy_a;

  logic [0:0]  en_b, os_b, start_b;
  logic        sync_b;
  logic [7:0]  presc_b;
  logic [0:0]  tick_b, clk_pre_b, busy_b;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  presc_multi #(.WIDTH(32), .CH(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .oneshot(os_a), .start(start_a),
    .sync(sync_a), .prescaler(presc_a),
    .tick(tick_a), .clk_pre(clk_pre_a), .busy(busy_a)
  );

  presc_multi #(.WIDTH(8), .CH(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .oneshot(os_b), .start(start_b),
    .sync(sync_b), .prescaler(presc_b),
    .tick(tick_b), .clk_pre(clk_pre_b), .busy(busy_b)
  );

  // Reference model: channels 0,1 = instance A, channel 2 = instance B.
  // Each running channel tracks the period length and edges elapsed in it.
  bit              m_run  [3];
  bit              m_tick [3];
  bit              m_clkp [3];
  longint unsigned m_ph   [3];
  longint unsigned m_per  [3];

  function automatic longint unsigned eff(longint unsigned r);
    return (r == 0) ? 64'd1 : r;
  endfunction

  task automatic model_ch(int c, bit e, bit os, bit st, bit sy, longint unsigned r);
    if (!m_run[c]) begin
      m_tick[c] = 1'b0;
      m_clkp[c] = 1'b0;
      if (e && (!os || st)) begin
        m_run[c] = 1'b1;
        m_per[c] = eff(r);
        m_ph[c]  = 0;
      end
    end else if (!e) begin
      m_run[c]  = 1'b0;
      m_tick[c] = 1'b0;
      m_clkp[c] = 1'b0;
    end else if (sy) begin
      m_per[c]  = eff(r);
      m_ph[c]   = 0;
      m_tick[c] = 1'b0;
      m_clkp[c] = (m_per[c] >= 2);
    end else begin
      m_ph[c] = m_ph[c] + 1;
      if (m_ph[c] == m_per[c]) begin
        m_tick[c] = 1'b1;
        m_ph[c]   = 0;
        m_per[c]  = eff(r);
        if (os) begin
          m_run[c]  = 1'b0;
          m_clkp[c] = 1'b0;
        end else begin
          m_clkp[c] = (m_per[c] >= 2);
        end
      end else begin
        m_tick[c] = 1'b0;
        m_clkp[c] = (m_ph[c] < (m_per[c] / 2));
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        m_run[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_clkp[c] = 1'b0;
        m_ph[c]   = 0;
        m_per[c]  = 1;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        model_ch(c, en_a[c], os_a[c], start_a[c], sync_a, 64'(presc_a[c*32 +: 32]));
      end
      model_ch(2, en_b[0], os_b[0], start_b[0], sync_b, 64'(presc_b));
    end
  end

  function automatic logic [8:0] got_all();
    return {tick_a, clk_pre_a, busy_a, tick_b, clk_pre_b, busy_b};
  endfunction

  function automatic logic [8:0] exp_all();
    return {m_tick[1], m_tick[0], m_clkp[1], m_clkp[0], m_run[1], m_run[0],
            m_tick[2], m_clkp[2], m_run[2]};
  endfunction

  // Drive everything to an idle state and let channels settle (no checks).
  task automatic go_idle(int n);
    en_a = '0; os_a = '0; start_a = '0; sync_a = 1'b0;
    en_b = '0; os_b = '0; start_b = '0; sync_b = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en_a = 2'b11; os_a = '0; start_a = '0; sync_a = 1'b0; presc_a = {32'd4, 32'd4};
    en_b = 1'b1;  os_b = '0; start_b = '0; sync_b = 1'b0; presc_b = 8'd4;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (got_all() !== 9'b0) begin
        err_cnt++;
        $display("FAIL reset_outputs t=%0d got=%b exp=%b", t, got_all(), 9'b0);
      end
    end
    go_idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_cnt++;
    if (got_all() !== exp_all()) begin
      err_cnt++;
      $display("FAIL reset_release got=%b exp=%b", got_all(), exp_all());
    end
  endtask

  task automatic test_periodic_update();
    int ticks[$];
    int exp_ticks[5];
    int hi16, hi8;
    exp_ticks = '{16, 32, 40, 48, 56};
    hi16 = 0; hi8 = 0;
    presc_a[31:0] = 32'd16;
    en_a = 2'b01;
    for (int t = 0; t < 64; t++) begin
      if (t == 20) presc_a[31:0] = 32'd8;
      @(posedge clk); #1;
      cmp_cnt++;
      if (got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL periodic_model t=%0d got=%b exp=%b", t, got_all(), exp_all());
      end
      if (tick_a[0]) ticks.push_back(t);
      if (t >= 16 && t < 32 && clk_pre_a[0]) hi16++;
      if (t >= 32 && t < 40 && clk_pre_a[0]) hi8++;
    end
    cmp_cnt++;
    if (ticks.size() != 5) begin
      err_cnt++;
      $display("FAIL periodic_tick_count got=%0d exp=5", ticks.size());
    end
    for (int k = 0; k < 5 && k < ticks.size(); k++) begin
      cmp_cnt++;
      if (ticks[k] != exp_ticks[k]) begin
        err_cnt++;
        $display("FAIL periodic_tick_edge k=%0d got=%0d exp=%0d", k, ticks[k], exp_ticks[k]);
      end
    end
    cmp_cnt++;
    if (hi16 != 8 || hi8 != 4) begin
      err_cnt++;
      $display("FAIL periodic_clk_pre_high got=%0d/%0d exp=8/4", hi16, hi8);
    end
    go_idle(2);
  endtask

  task automatic test_small_ratios();
    logic e;
    presc_a = {32'd1, 32'd0};
    en_a = 2'b11;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL ratio01_model t=%0d got=%b exp=%b", t, got_all(), exp_all());
      end
      if (t >= 1) begin
        cmp_cnt++;
        if (tick_a !== 2'b11 || clk_pre_a !== 2'b00) begin
          err_cnt++;
          $display("FAIL ratio01_const t=%0d got=%b_%b exp=11_00", t, tick_a, clk_pre_a);
        end
      end
    end
    go_idle(2);
    presc_a = {32'd0, 32'd3};
    en_a = 2'b01;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      e = (t > 0) && (t % 3 == 0);
      cmp_cnt++;
      if (tick_a[0] !== e || clk_pre_a[0] !== e || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL ratio3 t=%0d got=%b_%b exp=%b_%b", t, tick_a[0], clk_pre_a[0], e, e);
      end
    end
    go_idle(2);
  endtask

  task automatic test_oneshot();
    int nt;
    nt = 0;
    presc_a[31:0] = 32'd5;
    os_a = 2'b01;
    en_a = 2'b01;
    start_a = 2'b01;
    for (int t = 0; t < 15; t++) begin
      if (t == 1) start_a = 2'b00;
      if (t == 2) start_a = 2'b01;
      if (t == 3) start_a = 2'b00;
      @(posedge clk); #1;
      if (tick_a[0]) nt++;
      cmp_cnt++;
      if (tick_a[0] !== (t == 5) || busy_a[0] !== (t < 5) || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL oneshot t=%0d got=%b_%b exp=%b_%b", t, tick_a[0], busy_a[0], (t == 5), (t < 5));
      end
    end
    cmp_cnt++;
    if (nt != 1) begin
      err_cnt++;
      $display("FAIL oneshot_count got=%0d exp=1", nt);
    end
    go_idle(2);
  endtask

  task automatic test_sync();
    logic [1:0] e;
    presc_a = {32'd10, 32'd6};
    en_a = 2'b11;
    for (int t = 0; t < 46; t++) begin
      if (t == 23) sync_a = 1'b1;
      if (t == 24) sync_a = 1'b0;
      @(posedge clk); #1;
      e[0] = (t > 0) && ((t < 23) ? (t % 6 == 0) : (t > 23 && (t - 23) % 6 == 0));
      e[1] = (t > 0) && ((t < 23) ? (t % 10 == 0) : (t > 23 && (t - 23) % 10 == 0));
      cmp_cnt++;
      if (tick_a !== e || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL sync_ticks t=%0d got=%b exp=%b", t, tick_a, e);
      end
      if (t == 23) begin
        cmp_cnt++;
        if ({tick_a, clk_pre_a, busy_a} !== 6'b00_11_11) begin
          err_cnt++;
          $display("FAIL sync_restart got=%b exp=%b", {tick_a, clk_pre_a, busy_a}, 6'b00_11_11);
        end
      end
    end
    go_idle(2);
    // sync landing on a wrap edge suppresses that tick
    presc_a = {32'd0, 32'd6};
    en_a = 2'b01;
    for (int t = 0; t < 25; t++) begin
      if (t == 12) sync_a = 1'b1;
      if (t == 13) sync_a = 1'b0;
      @(posedge clk); #1;
      cmp_cnt++;
      if (tick_a[0] !== (t == 6 || t == 18 || t == 24) || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL sync_on_wrap t=%0d got=%b exp=%b", t, tick_a[0], (t == 6 || t == 18 || t == 24));
      end
    end
    go_idle(2);
  endtask

  task automatic test_abort();
    logic e;
    presc_a = {32'd0, 32'd8};
    en_a = 2'b01;
    for (int t = 0; t < 41; t++) begin
      if (t == 8)  en_a = 2'b00;
      if (t == 9)  en_a = 2'b01;
      if (t == 21) rst = 1'b0;
      if (t == 22) rst = 1'b1;
      @(posedge clk); #1;
      e = (t == 17 || t == 30 || t == 38);
      cmp_cnt++;
      if (tick_a[0] !== e || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL abort_ticks t=%0d got=%b exp=%b", t, tick_a[0], e);
      end
      if (t == 8 || t == 21) begin
        cmp_cnt++;
        if ({tick_a, clk_pre_a, busy_a} !== 6'b0) begin
          err_cnt++;
          $display("FAIL abort_outputs t=%0d got=%b exp=%b", t, {tick_a, clk_pre_a, busy_a}, 6'b0);
        end
      end
    end
    go_idle(2);
  endtask

  task automatic test_width8();
    int hi, lo;
    logic e;
    hi = 0; lo = 0;
    presc_b = 8'd255;
    en_b = 1'b1;
    for (int t = 0; t < 770; t++) begin
      @(posedge clk); #1;
      e = (t > 0) && (t % 255 == 0);
      cmp_cnt++;
      if (tick_b[0] !== e || got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL w8_ticks t=%0d got=%b exp=%b", t, tick_b[0], e);
      end
      if (t >= 255 && t < 510) begin
        if (clk_pre_b[0]) hi++; else lo++;
      end
    end
    cmp_cnt++;
    if (hi != 127 || lo != 128) begin
      err_cnt++;
      $display("FAIL w8_duty got=%0d/%0d exp=127/128", hi, lo);
    end
    go_idle(2);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4000; t++) begin
      rst = ($urandom_range(0, 799) != 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 29) == 0) en_a[c] = ~en_a[c];
        if ($urandom_range(0, 59) == 0) os_a[c] = ~os_a[c];
        start_a[c] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 14) == 0) presc_a[c*32 +: 32] = 32'($urandom_range(0, 12));
      end
      sync_a = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 29) == 0) en_b[0] = ~en_b[0];
      if ($urandom_range(0, 59) == 0) os_b[0] = ~os_b[0];
      start_b[0] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 14) == 0)
        presc_b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 20));
      sync_b = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
      cmp_cnt++;
      if (got_all() !== exp_all()) begin
        err_cnt++;
        $display("FAIL random_model t=%0d got=%b exp=%b", t, got_all(), exp_all());
      end
    end
    rst = 1'b1;
    go_idle(2);
  endtask

  initial begin
    rst = 1'b0;
    presc_a = '0;
    presc_b = '0;
    go_idle(0);
    test_reset();
    test_periodic_update();
    test_small_ratios();
    test_oneshot();
    test_sync();
    test_abort();
    test_width8();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
